// File: rtl/demux_pkg.sv
// Shared types, constants and helpers for the demux_stream_nx stream demultiplexer.
// The optional per-channel delivery counters are enabled with the DEMUX_CNT_EN macro.
package demux_pkg;

    localparam int CNT_W  = 16;
    localparam int MAX_CH = 32;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [MAX_CH-1:0] vec;
        logic              in_range;
    } dec_t;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Decodes sel into an n-bit one-hot vector; an out-of-range sel yields an all-zero vector.
    function automatic dec_t onehot_dec(input logic [31:0] sel, input int n);
        dec_t d;
        d.vec      = '0;
        d.in_range = (sel < $unsigned(n));
        if (d.in_range) d.vec[sel[4:0]] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// Combinational channel decoder: binary select to NUM_CH one-hot plus an in-range flag.
module demux_onehot_dec
    import demux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot,
    output logic              in_range
);

    dec_t dec;

    always_comb begin
        dec = onehot_dec(32'(sel), NUM_CH);
    end

    assign onehot   = dec.vec[NUM_CH-1:0];
    assign in_range = dec.in_range;

    // Decoder bits above NUM_CH are always zero and intentionally left unused.
    generate
        if (NUM_CH < MAX_CH) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^dec.vec[MAX_CH-1:NUM_CH];
        end
    endgenerate

endmodule

// File: rtl/demux_stream_nx.sv
// 1-to-NUM_CH valid/ready stream demux with a registered holding stage and broadcast mode.
// Define DEMUX_CNT_EN to add the per-channel saturating delivered-beat counters on port cnt.
module demux_stream_nx
    import demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef DEMUX_CNT_EN
    output logic              err_sel,
    output logic [NUM_CH*CNT_W-1:0] cnt
`else
    output logic              err_sel
`endif
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] sel_hot;
    logic              sel_ok;
    logic              err_q, err_d;
    logic              accept;
    state_t            state;

    demux_onehot_dec #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_dec (
        .sel      (in_sel),
        .onehot   (sel_hot),
        .in_range (sel_ok)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state  = (pend_q == '0) ? ST_IDLE : ST_HOLD;
        data_d = data_q;
        err_d  = 1'b0;

        // Accept when every still-owed channel retires this cycle; out_ready->in_ready is combinational.
        in_ready = rst | ((pend_q & ~out_ready) == '0);
        accept   = in_valid & in_ready;

        case (state)
            ST_IDLE: pend_d = '0;
            default: pend_d = pend_q & ~out_ready;
        endcase

        if (accept) begin
            data_d = in_data;
            if (in_bcast) begin
                pend_d = '1;
            end else if (sel_ok) begin
                pend_d = sel_hot;
            end else begin
                pend_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            pend_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;

`ifdef DEMUX_CNT_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (pend_q[i] && out_ready[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_demux_stream_nx.sv
// Self-checking bench for demux_stream_nx: per-channel scoreboard queues plus directed checks.
// A second instance with NUM_CH=3 covers the out-of-range select case.
module tb_demux_stream_nx;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_bcast, err_sel;
    logic [7:0] in_data, out_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid, out_ready;

    logic       in_valid3, in_ready3, err_sel3;
    logic [1:0] in_sel3;
    logic [2:0] out_valid3, out_ready3;
    logic [7:0] out_data3;

`ifdef DEMUX_CNT_EN
    logic [63:0] cnt;
    logic [47:0] cnt3;
`endif

    int      n_checks = 0;
    int      n_fail   = 0;
    byte_q_t exp_q [4];

    always #5 clk = ~clk;

    demux_stream_nx #(.DATA_W(8), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_CNT_EN
        .err_sel   (err_sel),
        .cnt       (cnt)
`else
        .err_sel   (err_sel)
`endif
    );

    demux_stream_nx #(.DATA_W(8), .NUM_CH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .in_sel    (in_sel3),
        .in_bcast  (1'b0),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
`ifdef DEMUX_CNT_EN
        .err_sel   (err_sel3),
        .cnt       (cnt3)
`else
        .err_sel   (err_sel3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each per-channel handshake, push on each accepted beat.
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) exp_q[c].delete();
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    check($sformatf("sb_expected_ch%0d", c), 64'(exp_q[c].size() != 0), 64'd1);
                    if (exp_q[c].size() != 0)
                        check($sformatf("sb_data_ch%0d", c), 64'(out_data), 64'(exp_q[c].pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                for (int c = 0; c < 4; c++)
                    if (in_bcast || (int'(in_sel) == c)) exp_q[c].push_back(in_data);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        out_ready = 4'b0000; in_valid3 = 1'b0; in_sel3 = 2'd0; out_ready3 = 3'b000;

        // Reset then idle
        cyc(); cyc();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h1);
        rst = 1'b0;
        cyc();
        check("idle_out_valid", 64'(out_valid), 64'h0);
        check("idle_out_data",  64'(out_data),  64'h0);
        check("idle_in_ready",  64'(in_ready),  64'h1);
        check("idle_err_sel",   64'(err_sel),   64'h0);

        // Unicast with backpressure
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
        cyc();
        in_valid = 1'b0;
        #1;
        check("uni_out_valid", 64'(out_valid), 64'b0100);
        check("uni_out_data",  64'(out_data),  64'hA5);
        check("uni_in_ready",  64'(in_ready),  64'h0);
        repeat (3) cyc();
        check("uni_hold_valid", 64'(out_valid), 64'b0100);
        check("uni_hold_data",  64'(out_data),  64'hA5);
        out_ready = 4'b0100;
        #1;
        check("uni_ready_pass", 64'(in_ready), 64'h1);
        cyc();
        out_ready = 4'b0000;
        check("uni_retired", 64'(out_valid), 64'h0);

        // Broadcast with partial acceptance
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h3C; out_ready = 4'b0011;
        cyc();
        in_valid = 1'b0; in_bcast = 1'b0;
        #1;
        check("bc_all_valid", 64'(out_valid), 64'b1111);
        check("bc_in_ready0", 64'(in_ready),  64'h0);
        cyc();
        check("bc_partial",   64'(out_valid), 64'b1100);
        check("bc_data_held", 64'(out_data),  64'h3C);
        check("bc_in_ready1", 64'(in_ready),  64'h0);
        out_ready = 4'b1111;
        #1;
        check("bc_in_ready2", 64'(in_ready), 64'h1);
        cyc();
        check("bc_done", 64'(out_valid), 64'h0);

        // Back-to-back throughput
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 2'(i % 4); in_data = 8'(8'h10 + i);
            #1;
            check("b2b_in_ready", 64'(in_ready), 64'h1);
            cyc();
            check("b2b_out_valid", 64'(out_valid), 64'(4'b0001 << (i % 4)));
            check("b2b_out_data",  64'(out_data),  64'(8'h10 + i));
        end
        in_valid = 1'b0;
        cyc();
        check("b2b_drained", 64'(out_valid), 64'h0);
        check("b2b_no_err",  64'(err_sel),   64'h0);

        // Out-of-range select on the 3-channel instance
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data = 8'h77;
        #1;
        check("oor_in_ready_pre", 64'(in_ready3), 64'h1);
        cyc();
        in_valid3 = 1'b0;
        #1;
        check("oor_err_pulse", 64'(err_sel3),   64'h1);
        check("oor_no_valid",  64'(out_valid3), 64'h0);
        check("oor_in_ready",  64'(in_ready3),  64'h1);
        cyc();
        check("oor_err_clear", 64'(err_sel3),   64'h0);
        check("oor_still_idle", 64'(out_valid3), 64'h0);
`ifdef DEMUX_CNT_EN
        check("oor_cnt_unchanged", 64'(cnt3), 64'h0);
`endif

        // Reset while a beat is pending on channel 1
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h5A;
        cyc();
        in_valid = 1'b0;
        check("rh_pending", 64'(out_valid), 64'b0010);
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hEE;
        cyc();
        check("rh_cleared",  64'(out_valid), 64'h0);
        check("rh_in_ready", 64'(in_ready),  64'h1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
        cyc();
        check("rh_ignored_valid", 64'(out_valid), 64'h0);
        check("rh_data_reset",    64'(out_data),  64'h0);
        repeat (3) cyc();
        check("rh_never_sent", 64'(out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
        // Counter saturation on channel 0
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
        repeat (65537) cyc();
        in_valid = 1'b0;
        cyc();
        check("cnt0_saturated", 64'(cnt[15:0]),  64'hFFFF);
        check("cnt1_zero",      64'(cnt[31:16]), 64'h0);
`endif

        out_ready = 4'b0000;
        cyc();
        for (int c = 0; c < 4; c++)
            check($sformatf("sb_drained_ch%0d", c), 64'(exp_q[c].size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
